// File: rtl/i2c_target_regs.sv
// I2C target exposing a 256-byte register space through a byte-wide strobe port.
// Optional: define I2C_TGT_GLITCH_FILT_EN to add a 3-sample glitch filter on SCL/SDA.
module i2c_target_regs #(
    parameter logic [6:0] DEV_ADDR = 7'h50,
    parameter int         SYNC_ST  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    output logic       wr_en,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       rd_req,
    output logic [7:0] rd_addr,
    input  logic [7:0] rd_data,
    output logic       busy
);

    typedef enum logic [3:0] {
        IDLE, DEVADR, ACK_A, WORDADR, ACK_W, WRDATA, ACK_D, RDDATA, RD_ACK, IGNORE
    } state_t;

    state_t state, state_nxt;

    logic [SYNC_ST-1:0] scl_sync, sda_sync;
    logic scl_s, sda_s, scl_d, sda_d;
    logic scl_rise, scl_fall, start_det, stop_det;

    logic [3:0] bit_cnt, bit_cnt_nxt;
    logic [7:0] shift, shift_nxt;
    logic [7:0] pointer, pointer_nxt;
    logic       mack, mack_nxt;
    logic       load_pend, load_nxt;
    logic       sda_oe_nxt, busy_nxt, wr_en_nxt, rd_req_nxt;
    logic [7:0] wr_addr_nxt, wr_data_nxt, rd_addr_nxt;

    // Synchronizers preset high so reset release never looks like a bus edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync <= '1;
            sda_sync <= '1;
        end else begin
            scl_sync <= {scl_sync[SYNC_ST-2:0], scl_i};
            sda_sync <= {sda_sync[SYNC_ST-2:0], sda_i};
        end
    end

`ifdef I2C_TGT_GLITCH_FILT_EN
    logic [1:0] scl_hist, sda_hist;
    logic       scl_f, sda_f;

    always_ff @(posedge clk) begin
        if (rst) begin
            scl_hist <= '1;
            sda_hist <= '1;
            scl_f    <= 1'b1;
            sda_f    <= 1'b1;
        end else begin
            scl_hist <= {scl_hist[0], scl_sync[SYNC_ST-1]};
            sda_hist <= {sda_hist[0], sda_sync[SYNC_ST-1]};
            if (scl_sync[SYNC_ST-1] == scl_hist[0] && scl_hist[0] == scl_hist[1])
                scl_f <= scl_hist[0];
            if (sda_sync[SYNC_ST-1] == sda_hist[0] && sda_hist[0] == sda_hist[1])
                sda_f <= sda_hist[0];
        end
    end

    assign scl_s = scl_f;
    assign sda_s = sda_f;
`else
    assign scl_s = scl_sync[SYNC_ST-1];
    assign sda_s = sda_sync[SYNC_ST-1];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            scl_d <= 1'b1;
            sda_d <= 1'b1;
        end else begin
            scl_d <= scl_s;
            sda_d <= sda_s;
        end
    end

    assign scl_rise  = scl_s & ~scl_d;
    assign scl_fall  = ~scl_s & scl_d;
    assign start_det = scl_s & scl_d & sda_d & ~sda_s;
    assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Bus conditions override everything; otherwise act on SCL edges per state.
    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        shift_nxt   = shift;
        pointer_nxt = pointer;
        mack_nxt    = mack;
        load_nxt    = 1'b0;
        sda_oe_nxt  = sda_oe;
        busy_nxt    = busy;
        wr_en_nxt   = 1'b0;
        wr_addr_nxt = wr_addr;
        wr_data_nxt = wr_data;
        rd_req_nxt  = 1'b0;
        rd_addr_nxt = rd_addr;

        if (stop_det) begin
            state_nxt  = IDLE;
            sda_oe_nxt = 1'b0;
            busy_nxt   = 1'b0;
        end else if (start_det) begin
            state_nxt   = DEVADR;
            bit_cnt_nxt = 4'd0;
            sda_oe_nxt  = 1'b0;
            busy_nxt    = 1'b0;
        end else if (load_pend) begin
            shift_nxt  = rd_data;
            sda_oe_nxt = ~rd_data[7];
        end else begin
            case (state)
                DEVADR, WORDADR, WRDATA: begin
                    if (scl_rise && bit_cnt < 4'd8) begin
                        shift_nxt   = {shift[6:0], sda_s};
                        bit_cnt_nxt = bit_cnt + 4'd1;
                    end else if (scl_fall && bit_cnt == 4'd8) begin
                        bit_cnt_nxt = 4'd0;
                        if (state == DEVADR) begin
                            if (shift[7:1] == DEV_ADDR) begin
                                state_nxt  = ACK_A;
                                sda_oe_nxt = 1'b1;
                                busy_nxt   = 1'b1;
                            end else begin
                                state_nxt = IGNORE;
                            end
                        end else if (state == WORDADR) begin
                            state_nxt   = ACK_W;
                            pointer_nxt = shift;
                            sda_oe_nxt  = 1'b1;
                        end else begin
                            state_nxt   = ACK_D;
                            sda_oe_nxt  = 1'b1;
                            wr_en_nxt   = 1'b1;
                            wr_addr_nxt = pointer;
                            wr_data_nxt = shift;
                            pointer_nxt = pointer + 8'd1;
                        end
                    end
                end
                ACK_A: begin
                    if (scl_fall) begin
                        sda_oe_nxt  = 1'b0;
                        bit_cnt_nxt = 4'd0;
                        if (shift[0]) begin
                            state_nxt   = RDDATA;
                            rd_req_nxt  = 1'b1;
                            rd_addr_nxt = pointer;
                            load_nxt    = 1'b1;
                        end else begin
                            state_nxt = WORDADR;
                        end
                    end
                end
                ACK_W, ACK_D: begin
                    if (scl_fall) begin
                        sda_oe_nxt  = 1'b0;
                        bit_cnt_nxt = 4'd0;
                        state_nxt   = WRDATA;
                    end
                end
                RDDATA: begin
                    if (scl_rise) begin
                        bit_cnt_nxt = bit_cnt + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt == 4'd8) begin
                            state_nxt  = RD_ACK;
                            sda_oe_nxt = 1'b0;
                        end else begin
                            shift_nxt  = {shift[6:0], 1'b0};
                            sda_oe_nxt = ~shift[6];
                        end
                    end
                end
                RD_ACK: begin
                    if (scl_rise) begin
                        mack_nxt = sda_s;
                    end else if (scl_fall) begin
                        if (!mack) begin
                            state_nxt   = RDDATA;
                            bit_cnt_nxt = 4'd0;
                            pointer_nxt = pointer + 8'd1;
                            rd_req_nxt  = 1'b1;
                            rd_addr_nxt = pointer + 8'd1;
                            load_nxt    = 1'b1;
                        end else begin
                            state_nxt = IGNORE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt   <= 4'd0;
            shift     <= 8'h00;
            pointer   <= 8'h00;
            mack      <= 1'b1;
            load_pend <= 1'b0;
            sda_oe    <= 1'b0;
            busy      <= 1'b0;
            wr_en     <= 1'b0;
            wr_addr   <= 8'h00;
            wr_data   <= 8'h00;
            rd_req    <= 1'b0;
            rd_addr   <= 8'h00;
        end else begin
            bit_cnt   <= bit_cnt_nxt;
            shift     <= shift_nxt;
            pointer   <= pointer_nxt;
            mack      <= mack_nxt;
            load_pend <= load_nxt;
            sda_oe    <= sda_oe_nxt;
            busy      <= busy_nxt;
            wr_en     <= wr_en_nxt;
            wr_addr   <= wr_addr_nxt;
            wr_data   <= wr_data_nxt;
            rd_req    <= rd_req_nxt;
            rd_addr   <= rd_addr_nxt;
        end
    end

endmodule

// File: tb/tb_i2c_target_regs.sv
// Directed bench for i2c_target_regs: bit-banged I2C initiator on a wired-AND SDA line.
module tb_i2c_target_regs;

    localparam int Q = 100;

    logic       clk = 1'b0;
    logic       rst;
    logic       scl_drv, sda_drv;
    logic       scl_i, sda_i;
    logic       sda_oe, wr_en, rd_req, busy;
    logic [7:0] wr_addr, wr_data, rd_addr;
    logic [7:0] rd_data = 8'h00;

    int vec_cnt = 0;
    int err_cnt = 0;

    int         wr_cnt = 0, rd_cnt = 0, oe_cnt = 0;
    logic [7:0] wr_addr_log [0:63];
    logic [7:0] wr_data_log [0:63];
    logic [7:0] rd_addr_log [0:63];
    logic [7:0] mem [0:255];

    assign scl_i = scl_drv;
    assign sda_i = sda_drv & ~sda_oe;

    i2c_target_regs #(.DEV_ADDR(7'h50), .SYNC_ST(2)) dut (
        .clk     (clk),
        .rst     (rst),
        .scl_i   (scl_i),
        .sda_i   (sda_i),
        .sda_oe  (sda_oe),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_req  (rd_req),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    // Register-port model: log strobes and answer reads from mem one clk later.
    always @(negedge clk) begin
        if (wr_en) begin
            wr_addr_log[wr_cnt % 64] = wr_addr;
            wr_data_log[wr_cnt % 64] = wr_data;
            wr_cnt++;
        end
        if (rd_req) begin
            rd_addr_log[rd_cnt % 64] = rd_addr;
            rd_data = mem[rd_addr];
            rd_cnt++;
        end
        if (sda_oe) oe_cnt++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic scl_v, input logic sda_v);
        scl_drv = scl_v;
        sda_drv = sda_v;
        #Q;
    endtask

    task automatic i2c_start();
        applyStimulus(scl_drv, 1'b1);
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
    endtask

    task automatic i2c_stop();
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1);
    endtask

    task automatic send_bit(input logic b, input bit glitch);
        applyStimulus(1'b0, b);
        scl_drv = 1'b1;
        #Q;
        if (glitch) begin
            scl_drv = 1'b0;
            #10;
            scl_drv = 1'b1;
            #(Q - 10);
        end else begin
            #Q;
        end
        scl_drv = 1'b0;
        #Q;
    endtask

    task automatic recv_bit(output logic v);
        applyStimulus(1'b0, 1'b1);
        scl_drv = 1'b1;
        #Q;
        v = sda_i;
        #Q;
        scl_drv = 1'b0;
        #Q;
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack, input int glitch_bit = -1);
        for (int i = 7; i >= 0; i--) send_bit(b[i], glitch_bit == i);
        recv_bit(ack);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] v);
        for (int i = 7; i >= 0; i--) recv_bit(v[i]);
        send_bit(nack, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic       ack, b;
        logic [7:0] v;
        int wb, rb, ob;

        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hFF;
        mem[8'h20] = 8'h3C;
        mem[8'h21] = 8'h7E;
        mem[8'h40] = 8'h00;

        rst = 1'b1;
        scl_drv = 1'b1;
        sda_drv = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        checkOutput("rst_sda_oe", 32'(sda_oe), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_wr_en", 32'(wr_en), 32'd0);
        checkOutput("rst_rd_req", 32'(rd_req), 32'd0);
        checkOutput("rst_wr_addr", 32'(wr_addr), 32'd0);
        checkOutput("rst_rd_addr", 32'(rd_addr), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #(4 * Q);

        // Plain write of two bytes starting at 0x10
        wb = wr_cnt;
        i2c_start();
        send_byte(8'hA0, ack); checkOutput("wr_ack_dev", 32'(ack), 32'd0);
        checkOutput("wr_busy", 32'(busy), 32'd1);
        send_byte(8'h10, ack); checkOutput("wr_ack_word", 32'(ack), 32'd0);
        send_byte(8'h5A, ack); checkOutput("wr_ack_d0", 32'(ack), 32'd0);
        send_byte(8'hC3, ack); checkOutput("wr_ack_d1", 32'(ack), 32'd0);
        i2c_stop();
        checkOutput("wr_count", 32'(wr_cnt - wb), 32'd2);
        checkOutput("wr_addr0", 32'(wr_addr_log[wb % 64]), 32'h10);
        checkOutput("wr_data0", 32'(wr_data_log[wb % 64]), 32'h5A);
        checkOutput("wr_addr1", 32'(wr_addr_log[(wb + 1) % 64]), 32'h11);
        checkOutput("wr_data1", 32'(wr_data_log[(wb + 1) % 64]), 32'hC3);
        checkOutput("wr_busy_stop", 32'(busy), 32'd0);

        // Random read: set pointer, repeated start, read two bytes
        rb = rd_cnt;
        i2c_start();
        send_byte(8'hA0, ack); checkOutput("rd_ack_dev", 32'(ack), 32'd0);
        send_byte(8'h20, ack); checkOutput("rd_ack_word", 32'(ack), 32'd0);
        i2c_start();
        send_byte(8'hA1, ack); checkOutput("rd_ack_devr", 32'(ack), 32'd0);
        read_byte(1'b0, v); checkOutput("rd_byte0", 32'(v), 32'h3C);
        read_byte(1'b1, v); checkOutput("rd_byte1", 32'(v), 32'h7E);
        i2c_stop();
        checkOutput("rd_count", 32'(rd_cnt - rb), 32'd2);
        checkOutput("rd_addr0", 32'(rd_addr_log[rb % 64]), 32'h20);
        checkOutput("rd_addr1", 32'(rd_addr_log[(rb + 1) % 64]), 32'h21);
        checkOutput("rd_busy_stop", 32'(busy), 32'd0);

        // Address mismatch and general call are both left unanswered
        wb = wr_cnt; rb = rd_cnt; ob = oe_cnt;
        i2c_start();
        send_byte(8'hA2, ack); checkOutput("mm_nack_dev", 32'(ack), 32'd1);
        checkOutput("mm_busy", 32'(busy), 32'd0);
        send_byte(8'h00, ack); checkOutput("mm_nack_data", 32'(ack), 32'd1);
        i2c_stop();
        i2c_start();
        send_byte(8'h00, ack); checkOutput("gc_nack", 32'(ack), 32'd1);
        i2c_stop();
        checkOutput("mm_oe_count", 32'(oe_cnt - ob), 32'd0);
        checkOutput("mm_wr_count", 32'(wr_cnt - wb), 32'd0);
        checkOutput("mm_rd_count", 32'(rd_cnt - rb), 32'd0);
        checkOutput("mm_busy_end", 32'(busy), 32'd0);

        // Pointer wrap at 0xFF
        wb = wr_cnt;
        i2c_start();
        send_byte(8'hA0, ack);
        send_byte(8'hFF, ack);
        send_byte(8'h11, ack);
        send_byte(8'h22, ack); checkOutput("wrap_ack", 32'(ack), 32'd0);
        i2c_stop();
        checkOutput("wrap_count", 32'(wr_cnt - wb), 32'd2);
        checkOutput("wrap_addr0", 32'(wr_addr_log[wb % 64]), 32'hFF);
        checkOutput("wrap_addr1", 32'(wr_addr_log[(wb + 1) % 64]), 32'h00);
        checkOutput("wrap_data1", 32'(wr_data_log[(wb + 1) % 64]), 32'h22);

        // STOP after half a data byte discards it
        wb = wr_cnt;
        i2c_start();
        send_byte(8'hA0, ack);
        send_byte(8'h50, ack);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        i2c_stop();
        #(4 * Q);
        checkOutput("abort_wr_count", 32'(wr_cnt - wb), 32'd0);
        checkOutput("abort_sda_oe", 32'(sda_oe), 32'd0);
        checkOutput("abort_busy", 32'(busy), 32'd0);

        // Reset in the middle of a read byte of zeros
        i2c_start();
        send_byte(8'hA0, ack);
        send_byte(8'h40, ack);
        i2c_start();
        send_byte(8'hA1, ack);
        recv_bit(b); checkOutput("rrst_bit0", 32'(b), 32'd0);
        recv_bit(b);
        recv_bit(b);
        checkOutput("rrst_oe_before", 32'(sda_oe), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rrst_oe_after", 32'(sda_oe), 32'd0);
        checkOutput("rrst_busy_after", 32'(busy), 32'd0);
        scl_drv = 1'b1;
        sda_drv = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #(4 * Q);
        wb = wr_cnt;
        i2c_start();
        send_byte(8'hA0, ack); checkOutput("rrst_ack_dev", 32'(ack), 32'd0);
        send_byte(8'h05, ack);
        send_byte(8'h99, ack);
        i2c_stop();
        checkOutput("rrst_wr_count", 32'(wr_cnt - wb), 32'd1);
        checkOutput("rrst_wr_data", 32'(wr_data_log[wb % 64]), 32'h99);

        // One-clk SCL low pulse in the high phase of the first data bit
        wb = wr_cnt;
        i2c_start();
        send_byte(8'hA0, ack);
        send_byte(8'h30, ack);
        send_byte(8'hA5, ack, 7);
        i2c_stop();
        checkOutput("glitch_wr_count", 32'(wr_cnt - wb), 32'd1);
        checkOutput("glitch_wr_addr", 32'(wr_addr_log[wb % 64]), 32'h30);
`ifdef I2C_TGT_GLITCH_FILT_EN
        checkOutput("glitch_wr_data", 32'(wr_data_log[wb % 64]), 32'hA5);
`else
        checkOutput("glitch_wr_data", 32'(wr_data_log[wb % 64]), 32'hD2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
